imem_fetch_unit: RTL and testbench

Parametrised, synchronous-read instruction memory with a valid/ready fetch port and a sequential load port used to program it at run time. It replaces the fixed 256×32 combinational-read instruction store. It sits between the fetch stage, which issues addresses and consumes words with backpressure, and a boot/loader source that streams a program image in. Per-word loaded flags make fetches of never-written words detectable.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_ram.sv | 28 ++
 rtl/imem_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_imem_fetch_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch unit.
// The parity helper is used only when IMEM_PARITY_EN is defined.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W  = 8;
  localparam int unsigned IMEM_DATA_W  = 32;
  localparam int unsigned PARITY_MAX_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  // Zero-extended callers are fine: padding zeros do not change the parity.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-write, single synchronous-read storage array for the fetch unit.
// The read register only updates when a read is enabled, so it holds a stalled response.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: the array has no reset; validity is tracked by the loaded flags, and a
  // resettable array would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_unit.sv
// Run-time loadable instruction memory with valid/ready fetch port and loaded flags.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag mismatches.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DEPTH-1:0]  r_flags;
  logic              r_done;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic              r_rsp_hit;
  logic              r_rsp_miss;

  logic              w_wr;
  logic              w_at_top;
  logic              w_last;
  logic              w_accept;
  logic [RAM_W-1:0]  w_wdata;
  logic [RAM_W-1:0]  w_rd_data;
  logic              w_par_bad;

  assign w_wr     = (r_state == LOAD) && load_valid && !load_start;
  assign w_at_top = (r_ptr == ADDR_W'(DEPTH - 1));
  assign w_last   = w_wr && (load_last || w_at_top);

  assign req_ready = !rst && (r_state == IDLE) && !load_start && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;

  // NOTE: next-state is assigned its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (load_start) w_state_nxt = LOAD;
      LOAD:    if (w_last)     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (load_start) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_flags <= '0;
      end else if (w_wr) begin
        r_flags[r_ptr] <= 1'b1;
        r_count        <= r_count + 1'b1;
        if (!w_at_top) r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_miss  <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_addr  <= req_addr;
      r_rsp_hit   <= r_flags[req_addr];
      r_rsp_miss  <= !r_flags[req_addr];
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  assign w_wdata   = {even_parity(PARITY_MAX_W'(load_data)), load_data};
  assign w_par_bad = r_rsp_hit &&
                     (even_parity(PARITY_MAX_W'(w_rd_data[DATA_W-1:0])) != w_rd_data[DATA_W]);
`else
  assign w_wdata   = load_data;
  assign w_par_bad = 1'b0;
`endif

  imem_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (RAM_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_accept),
    .i_raddr (req_addr),
    .o_rdata (w_rd_data)
  );

  assign load_busy  = (r_state == LOAD);
  assign load_done  = r_done;
  assign load_count = r_count;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_addr   = r_rsp_addr;
  // Unloaded words read as zero; the RAM output is only meaningful on a hit.
  assign rsp_data   = r_rsp_hit ? w_rd_data[DATA_W-1:0] : '0;
  assign rsp_err    = r_rsp_miss || w_par_bad;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit (depth 8): directed tables, corner sequences
// and randomized fetch traffic against a word/flag array model with a one-entry response slot.
module tb_imem_fetch_unit;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start, load_valid, load_last;
  logic [DW-1:0] load_data;
  logic          load_busy, load_done;
  logic [AW:0]   load_count;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;

  imem_fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_count (load_count),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } vec_t;

  vec_t          vecs [5];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_flag [DEPTH];
  int            m_count;
  logic [DW-1:0] img    [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_flag[i] = 1'b0;
    m_count = 0;
  endtask

  task automatic model_write(input int i);
    m_mem[i]  = img[i];
    m_flag[i] = 1'b1;
    m_count++;
  endtask

  // Starts (or restarts) a load of img[0..n-1]; leaves the bench one cycle after load_done.
  task automatic load_words(input int n, input bit use_last, input string tag);
    load_start = 1'b1;
    load_valid = 1'b0;
    settle();
    check({tag, " req_ready at start"}, req_ready, 1'b0);
    step();
    load_start = 1'b0;
    model_clear();
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = use_last && (i == n - 1);
      settle();
      check({tag, " busy"}, load_busy, 1'b1);
      check({tag, " done early"}, load_done, 1'b0);
      check({tag, " req_ready in load"}, req_ready, 1'b0);
      step();
      model_write(i);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    req_valid  = 1'b0;
    rsp_ready  = 1'b1;
    settle();
    check({tag, " done pulse"}, load_done, 1'b1);
    check({tag, " busy after"}, load_busy, 1'b0);
    check({tag, " count"}, load_count, m_count);
    check({tag, " req_ready idle"}, req_ready, 1'b1);
    step();
    settle();
    check({tag, " done one cycle"}, load_done, 1'b0);
  endtask

  task automatic fetch_check(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                             input logic exp_e, input string tag);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    settle();
    check({tag, " req_ready"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    settle();
    check({tag, " rsp_valid"}, rsp_valid, 1'b1);
    check({tag, " rsp_addr"}, rsp_addr, a);
    check({tag, " rsp_data"}, rsp_data, exp_d);
    check({tag, " rsp_err"}, rsp_err, exp_e);
    step();
    settle();
    check({tag, " rsp cleared"}, rsp_valid, 1'b0);
  endtask

  task automatic fetch_model(input logic [AW-1:0] a, input string tag);
    fetch_check(a, m_flag[a] ? m_mem[a] : '0, !m_flag[a], tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pd;
    bit            pend_v;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    logic          pend_e;
    logic          exp_ready;
    logic          acc;
    logic          rr;
    logic [AW-1:0] a;
    int            n;
    bit            ul;

    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;

    vecs[0] = '{addr: 3'd2, data: 32'h33, err: 1'b0};
    vecs[1] = '{addr: 3'd7, data: 32'h00, err: 1'b1};
    vecs[2] = '{addr: 3'd0, data: 32'h11, err: 1'b0};
    vecs[3] = '{addr: 3'd3, data: 32'h44, err: 1'b0};
    vecs[4] = '{addr: 3'd4, data: 32'h00, err: 1'b1};

    // Reset state
    step();
    settle();
    check("reset req_ready", req_ready, 1'b0);
    check("reset load_busy", load_busy, 1'b0);
    check("reset load_done", load_done, 1'b0);
    check("reset load_count", load_count, 0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_addr", rsp_addr, 0);
    check("reset rsp_err", rsp_err, 1'b0);
    step();
    rst = 1'b0;
    model_clear();

    // Fresh image load and table-driven fetches
    img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
    load_words(4, 1'b1, "fresh");
    check("fresh count is 4", load_count, 4);
    for (int i = 0; i < 5; i++)
      fetch_check(vecs[i].addr, vecs[i].data, vecs[i].err, $sformatf("vec%0d", i));

    // Backpressure: fetch 0,1,2 with rsp_ready low for three cycles
    req_valid = 1'b1; req_addr = 3'd0; rsp_ready = 1'b0;
    settle();
    check("bp accept0 ready", req_ready, 1'b1);
    step();
    req_addr = 3'd1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("bp stall rsp_valid", rsp_valid, 1'b1);
      check("bp stall data", rsp_data, 32'h11);
      check("bp stall addr", rsp_addr, 3'd0);
      check("bp stall req_ready", req_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    settle();
    check("bp release ready", req_ready, 1'b1);
    check("bp release data", rsp_data, 32'h11);
    step();
    req_addr = 3'd2;
    settle();
    check("bp second valid", rsp_valid, 1'b1);
    check("bp second data", rsp_data, 32'h22);
    step();
    req_valid = 1'b0;
    settle();
    check("bp third valid", rsp_valid, 1'b1);
    check("bp third data", rsp_data, 32'h33);
    check("bp third addr", rsp_addr, 3'd2);
    step();
    settle();
    check("bp drained", rsp_valid, 1'b0);

    // Full-depth load without load_last: auto-completes, no wrap
    for (int i = 0; i < DEPTH; i++) img[i] = 32'hA500_0000 + 32'(i * 3 + 1);
    load_words(DEPTH, 1'b0, "full");
    check("full count is 8", load_count, 8);
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    step();
    load_valid = 1'b0;
    settle();
    check("full idle ignores valid", load_busy, 1'b0);
    check("full count held", load_count, 8);
    fetch_check(3'd0, 32'hA500_0001, 1'b0, "full word0 intact");
    fetch_model(3'd7, "full word7");

    // Load blocks fetch; pending response survives; restart clears flags
    req_valid = 1'b1; req_addr = 3'd1; rsp_ready = 1'b0;
    settle();
    check("lbf accept", req_ready, 1'b1);
    pd = m_mem[1];
    step();
    load_start = 1'b1;
    settle();
    check("lbf start blocks ready", req_ready, 1'b0);
    check("lbf pending valid", rsp_valid, 1'b1);
    step();
    load_start = 1'b0;
    model_clear();
    img[0] = 32'hB0; img[1] = 32'hB1;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = img[i];
      settle();
      check("lbf ready in load", req_ready, 1'b0);
      check("lbf pending held", rsp_valid, 1'b1);
      check("lbf pending data", rsp_data, pd);
      step();
      model_write(i);
    end
    load_valid = 1'b0;
    rsp_ready  = 1'b1;
    settle();
    check("lbf pending before restart", rsp_data, pd);
    img[0] = 32'hC0; img[1] = 32'hC1;
    load_words(2, 1'b1, "restart");
    check("restart pending consumed", rsp_valid, 1'b0);
    fetch_check(3'd3, '0, 1'b1, "restart old addr3");
    fetch_model(3'd1, "restart addr1");

    // Reset mid-load after two words
    img[0] = 32'hD0; img[1] = 32'hD1; img[2] = 32'hD2;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = img[i];
      step();
      model_write(i);
    end
    load_valid = 1'b1; load_data = img[2]; load_last = 1'b1; rst = 1'b1;
    settle();
    check("rml req_ready in rst", req_ready, 1'b0);
    step();
    rst = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    model_clear();
    settle();
    check("rml busy", load_busy, 1'b0);
    check("rml no done", load_done, 1'b0);
    check("rml rsp_valid", rsp_valid, 1'b0);
    check("rml count", load_count, 0);
    step();
    settle();
    check("rml still no done", load_done, 1'b0);
    fetch_check(3'd0, '0, 1'b1, "rml addr0");

`ifdef IMEM_PARITY_EN
    img[0] = 32'h1; img[1] = 32'h3; img[2] = 32'h7;
    load_words(3, 1'b1, "par");
    u_dut.u_ram.r_mem[2][DW] = ~u_dut.u_ram.r_mem[2][DW];
    fetch_check(3'd2, 32'h7, 1'b1, "parity flip");
    fetch_model(3'd1, "parity clean");
`endif

    // Randomized loads and fetch traffic against the model
    for (int r = 0; r < 3; r++) begin
      n  = int'($urandom_range(1, DEPTH));
      ul = (n < DEPTH) ? 1'b1 : bit'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      load_words(n, ul, "rand load");
      pend_v = 1'b0; pend_a = '0; pend_d = '0; pend_e = 1'b0;
      for (int cyc = 0; cyc < 150; cyc++) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, DEPTH - 1));
        rsp_ready = ($urandom_range(0, 3) != 0);
        settle();
        exp_ready = !pend_v || rsp_ready;
        check("rand req_ready", req_ready, exp_ready);
        check("rand rsp_valid", rsp_valid, pend_v);
        if (pend_v) begin
          check("rand rsp_addr", rsp_addr, pend_a);
          check("rand rsp_data", rsp_data, pend_d);
          check("rand rsp_err", rsp_err, pend_e);
        end
        acc = req_valid && exp_ready;
        a   = req_addr;
        rr  = rsp_ready;
        step();
        if (pend_v && rr) pend_v = 1'b0;
        if (acc) begin
          pend_v = 1'b1;
          pend_a = a;
          pend_d = m_flag[a] ? m_mem[a] : '0;
          pend_e = !m_flag[a];
        end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      settle();
      check("rand drained", rsp_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
